// File: rtl/stereo_matrix_interp4.sv
// Stereo L/R to mid/side matrix, then a x4 linear-interpolating upsampler from
// the 48 kHz strobe to the 192 kHz strobe feeding the multiplex stage.
module stereo_matrix_interp4 #(
  parameter int NBITS = 18
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clken_48,
  input  logic                    clken_192,
  input  logic signed [NBITS-1:0] left_in,
  input  logic signed [NBITS-1:0] right_in,
  output logic signed [NBITS-1:0] li_sum,
  output logic signed [NBITS-1:0] li_diff,
  output logic                    ready_192,
  output logic                    sync_err
);

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_t;

  phase_t phase_q, phase_d;

  logic signed [NBITS-1:0] prev_sum_q, prev_sum_d, cur_sum_q, cur_sum_d;
  logic signed [NBITS-1:0] prev_diff_q, prev_diff_d, cur_diff_q, cur_diff_d;
  logic signed [NBITS-1:0] li_sum_q, li_sum_d, li_diff_q, li_diff_d;
  logic                    ready_q, ready_d;
  logic                    sync_err_q, sync_err_d;

  logic signed [NBITS:0]   sum_w, diff_w;
  logic signed [NBITS-1:0] m_sum, m_diff;

  // prev + floor(k*(cur-prev)/4); the result lies between prev and cur, so the
  // truncation back to NBITS never loses information.
  function automatic logic signed [NBITS-1:0] interp(
    input logic signed [NBITS-1:0] p,
    input logic signed [NBITS-1:0] c,
    input phase_t                  k
  );
    logic signed [NBITS:0]   d;
    logic signed [NBITS+2:0] dx;
    logic signed [NBITS+2:0] kd;
    d  = {c[NBITS-1], c} - {p[NBITS-1], p};
    dx = {{2{d[NBITS]}}, d};
    case (k)
      PH0:     kd = '0;
      PH1:     kd = dx;
      PH2:     kd = dx <<< 1;
      default: kd = dx + (dx <<< 1);
    endcase
    return p + NBITS'(kd >>> 2);
  endfunction

  always_comb begin
    sum_w  = {left_in[NBITS-1], left_in} + {right_in[NBITS-1], right_in};
    diff_w = {left_in[NBITS-1], left_in} - {right_in[NBITS-1], right_in};
    m_sum  = NBITS'(sum_w >>> 1);
    m_diff = NBITS'(diff_w >>> 1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= PH3;
      prev_sum_q  <= '0;
      cur_sum_q   <= '0;
      prev_diff_q <= '0;
      cur_diff_q  <= '0;
      li_sum_q    <= '0;
      li_diff_q   <= '0;
      ready_q     <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      prev_sum_q  <= prev_sum_d;
      cur_sum_q   <= cur_sum_d;
      prev_diff_q <= prev_diff_d;
      cur_diff_q  <= cur_diff_d;
      li_sum_q    <= li_sum_d;
      li_diff_q   <= li_diff_d;
      ready_q     <= ready_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Phase stalls at PH3 when the 48 kHz strobe goes missing (no extrapolation).
  always_comb begin
    phase_d = phase_q;
    if (clken_192) begin
      if (clken_48) begin
        phase_d = PH0;
      end else begin
        case (phase_q)
          PH0:     phase_d = PH1;
          PH1:     phase_d = PH2;
          default: phase_d = PH3;
        endcase
      end
    end
  end

  // Interpolation uses the post-capture prev/cur and next phase, so a
  // coincident 48/192 strobe pair is reflected in the very next output.
  always_comb begin
    prev_sum_d  = prev_sum_q;
    cur_sum_d   = cur_sum_q;
    prev_diff_d = prev_diff_q;
    cur_diff_d  = cur_diff_q;
    li_sum_d    = li_sum_q;
    li_diff_d   = li_diff_q;
    ready_d     = clken_192;
    sync_err_d  = sync_err_q;
    if (clken_48) begin
      prev_sum_d  = cur_sum_q;
      cur_sum_d   = m_sum;
      prev_diff_d = cur_diff_q;
      cur_diff_d  = m_diff;
    end
    if (clken_192) begin
      li_sum_d  = interp(prev_sum_d, cur_sum_d, phase_d);
      li_diff_d = interp(prev_diff_d, cur_diff_d, phase_d);
      if (!clken_48 && phase_q == PH3) begin
        sync_err_d = 1'b1;
      end
    end
  end

  assign li_sum    = li_sum_q;
  assign li_diff   = li_diff_q;
  assign ready_192 = ready_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_stereo_matrix_interp4.sv
// Directed bench for stereo_matrix_interp4: hand-computed matrix/interpolation
// values, strobe timing, sync error and reset behaviour.
module tb_stereo_matrix_interp4;
  localparam int NBITS = 18;

  logic                    clock = 1'b0;
  logic                    reset, clken_48, clken_192;
  logic signed [NBITS-1:0] left_in, right_in, li_sum, li_diff;
  logic                    ready_192, sync_err;

  int     n_cmp = 0;
  int     n_bad = 0;
  integer obs_s[4];
  integer obs_d[4];
  logic   obs_r[4];
  logic   obs_ri[4];

  always #5 clock = ~clock;

  stereo_matrix_interp4 #(.NBITS(NBITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .clken_48  (clken_48),
    .clken_192 (clken_192),
    .left_in   (left_in),
    .right_in  (right_in),
    .li_sum    (li_sum),
    .li_diff   (li_diff),
    .ready_192 (ready_192),
    .sync_err  (sync_err)
  );

  task automatic step(input bit r, input bit c48, input bit c192, input int l, input int rr);
    reset     = r;
    clken_48  = c48;
    clken_192 = c192;
    left_in   = l[NBITS-1:0];
    right_in  = rr[NBITS-1:0];
    @(posedge clock);
    #1;
    reset     = 1'b0;
    clken_48  = 1'b0;
    clken_192 = 1'b0;
  endtask

  // One 48 kHz period: four 192 kHz strobes (first coincident with clken_48),
  // each followed by an idle clock; records outputs after each.
  task automatic run_period(input int l, input int r);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, i == 0, 1'b1, l, r);
      obs_s[i] = li_sum;
      obs_d[i] = li_diff;
      obs_r[i] = ready_192;
      step(1'b0, 1'b0, 1'b0, l, r);
      obs_ri[i] = ready_192;
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    n_cmp++; if (li_sum !== 0) begin n_bad++; $display("FAIL reset_sum: got %0d want 0", li_sum); end
    n_cmp++; if (li_diff !== 0) begin n_bad++; $display("FAIL reset_diff: got %0d want 0", li_diff); end
    n_cmp++; if (ready_192 !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready_192); end
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", sync_err); end
  endtask

  task automatic test_settle();
    int es[4];
    es = '{0, 250, 500, 750};
    run_period(1000, 1000);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_s[i] !== es[i]) begin n_bad++; $display("FAIL settle_p1_sum[%0d]: got %0d want %0d", i, obs_s[i], es[i]); end
      n_cmp++; if (obs_d[i] !== 0) begin n_bad++; $display("FAIL settle_p1_diff[%0d]: got %0d want 0", i, obs_d[i]); end
      n_cmp++; if (obs_r[i] !== 1'b1) begin n_bad++; $display("FAIL settle_ready_pulse[%0d]: got %b want 1", i, obs_r[i]); end
      n_cmp++; if (obs_ri[i] !== 1'b0) begin n_bad++; $display("FAIL settle_ready_idle[%0d]: got %b want 0", i, obs_ri[i]); end
    end
    run_period(1000, 1000);
    run_period(1000, 1000);
    run_period(1000, 1000);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_s[i] !== 1000) begin n_bad++; $display("FAIL settle_p4_sum[%0d]: got %0d want 1000", i, obs_s[i]); end
      n_cmp++; if (obs_d[i] !== 0) begin n_bad++; $display("FAIL settle_p4_diff[%0d]: got %0d want 0", i, obs_d[i]); end
    end
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL settle_err: got %b want 0", sync_err); end
  endtask

  task automatic test_ramp();
    int e0[4];
    int e1[4];
    e0 = '{1000, 750, 500, 250};
    e1 = '{0, 100, 200, 300};
    run_period(0, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_s[i] !== e0[i]) begin n_bad++; $display("FAIL ramp_down_sum[%0d]: got %0d want %0d", i, obs_s[i], e0[i]); end
    end
    run_period(400, 400);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_s[i] !== e1[i]) begin n_bad++; $display("FAIL ramp_up_sum[%0d]: got %0d want %0d", i, obs_s[i], e1[i]); end
      n_cmp++; if (obs_d[i] !== 0) begin n_bad++; $display("FAIL ramp_up_diff[%0d]: got %0d want 0", i, obs_d[i]); end
    end
    run_period(400, 400);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_s[i] !== 400) begin n_bad++; $display("FAIL ramp_hold_sum[%0d]: got %0d want 400", i, obs_s[i]); end
    end
  endtask

  task automatic test_floor();
    int es[4];
    es = '{0, -1, -2, -3};
    run_period(0, 0);
    run_period(-3, -3);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_s[i] !== es[i]) begin n_bad++; $display("FAIL floor_sum[%0d]: got %0d want %0d", i, obs_s[i], es[i]); end
      n_cmp++; if (obs_d[i] !== 0) begin n_bad++; $display("FAIL floor_diff[%0d]: got %0d want 0", i, obs_d[i]); end
    end
  endtask

  task automatic test_extremes();
    int ed[4];
    ed = '{131071, 65535, -1, -65537};
    run_period(131071, -131072);
    run_period(131071, -131072);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_s[i] !== -1) begin n_bad++; $display("FAIL ext_sum[%0d]: got %0d want -1", i, obs_s[i]); end
      n_cmp++; if (obs_d[i] !== 131071) begin n_bad++; $display("FAIL ext_diff_pos[%0d]: got %0d want 131071", i, obs_d[i]); end
    end
    run_period(-131072, 131071);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_d[i] !== ed[i]) begin n_bad++; $display("FAIL ext_swing_diff[%0d]: got %0d want %0d", i, obs_d[i], ed[i]); end
    end
    run_period(-131072, 131071);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_s[i] !== -1) begin n_bad++; $display("FAIL ext_swap_sum[%0d]: got %0d want -1", i, obs_s[i]); end
      n_cmp++; if (obs_d[i] !== -131072) begin n_bad++; $display("FAIL ext_diff_neg[%0d]: got %0d want -131072", i, obs_d[i]); end
    end
  endtask

  task automatic test_missing_strobe();
    run_period(600, 200);
    run_period(600, 200);
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL miss_err_before: got %b want 0", sync_err); end
    step(1'b0, 1'b0, 1'b1, 600, 200);
    n_cmp++; if (li_sum !== 400) begin n_bad++; $display("FAIL miss_hold_sum: got %0d want 400", li_sum); end
    n_cmp++; if (li_diff !== 200) begin n_bad++; $display("FAIL miss_hold_diff: got %0d want 200", li_diff); end
    n_cmp++; if (ready_192 !== 1'b1) begin n_bad++; $display("FAIL miss_ready: got %b want 1", ready_192); end
    n_cmp++; if (sync_err !== 1'b1) begin n_bad++; $display("FAIL miss_err_set: got %b want 1", sync_err); end
    step(1'b0, 1'b0, 1'b0, 600, 200);
    run_period(600, 200);
    n_cmp++; if (sync_err !== 1'b1) begin n_bad++; $display("FAIL miss_err_sticky: got %b want 1", sync_err); end
    n_cmp++; if (obs_s[0] !== 400) begin n_bad++; $display("FAIL miss_resume_sum: got %0d want 400", obs_s[0]); end
    step(1'b1, 1'b0, 1'b0, 0, 0);
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL miss_err_reset: got %b want 0", sync_err); end
  endtask

  task automatic test_reset_mid();
    run_period(600, 200);
    run_period(600, 200);
    step(1'b0, 1'b1, 1'b1, 600, 200);
    step(1'b0, 1'b0, 1'b0, 600, 200);
    step(1'b0, 1'b0, 1'b1, 600, 200);
    step(1'b0, 1'b0, 1'b0, 600, 200);
    step(1'b0, 1'b0, 1'b1, 600, 200);
    n_cmp++; if (li_sum !== 400) begin n_bad++; $display("FAIL rmid_pre_sum: got %0d want 400", li_sum); end
    step(1'b1, 1'b0, 1'b0, 600, 200);
    n_cmp++; if (li_sum !== 0) begin n_bad++; $display("FAIL rmid_sum: got %0d want 0", li_sum); end
    n_cmp++; if (li_diff !== 0) begin n_bad++; $display("FAIL rmid_diff: got %0d want 0", li_diff); end
    n_cmp++; if (ready_192 !== 1'b0) begin n_bad++; $display("FAIL rmid_ready: got %b want 0", ready_192); end
    step(1'b0, 1'b0, 1'b1, 0, 0);
    n_cmp++; if (sync_err !== 1'b1) begin n_bad++; $display("FAIL rmid_err_lone192: got %b want 1", sync_err); end
    n_cmp++; if (li_sum !== 0) begin n_bad++; $display("FAIL rmid_lone192_sum: got %0d want 0", li_sum); end
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 800, 800);
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL rmid_err_coincident: got %b want 0", sync_err); end
    n_cmp++; if (ready_192 !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_coincident: got %b want 1", ready_192); end
    n_cmp++; if (li_sum !== 0) begin n_bad++; $display("FAIL rmid_sum_coincident: got %0d want 0", li_sum); end
  endtask

  task automatic test_c48_only();
    step(1'b0, 1'b1, 1'b0, 200, 200);
    n_cmp++; if (ready_192 !== 1'b0) begin n_bad++; $display("FAIL c48only_ready: got %b want 0", ready_192); end
    n_cmp++; if (li_sum !== 0) begin n_bad++; $display("FAIL c48only_hold_sum: got %0d want 0", li_sum); end
    step(1'b0, 1'b0, 1'b1, 0, 0);
    n_cmp++; if (li_sum !== 650) begin n_bad++; $display("FAIL c48only_phase1_sum: got %0d want 650", li_sum); end
    n_cmp++; if (li_diff !== 0) begin n_bad++; $display("FAIL c48only_phase1_diff: got %0d want 0", li_diff); end
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL c48only_err: got %b want 0", sync_err); end
  endtask

  initial begin
    reset     = 1'b1;
    clken_48  = 1'b0;
    clken_192 = 1'b0;
    left_in   = '0;
    right_in  = '0;
    test_reset();
    test_settle();
    test_ramp();
    test_floor();
    test_extremes();
    test_missing_strobe();
    test_reset_mid();
    test_c48_only();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stereo_matrix_interp4.md
Name: stereo_matrix_interp4

Overview:
Upstream feeder of the 192 kHz stereo multiplex/FM block. It takes 48 kHz left/right audio and forms the mid (L+R)/2 and side (L-R)/2 signals. It upsamples both by 4 using linear interpolation and presents them at the 192 kHz rate. li_sum drives the multiplex block's LI_LEFT input; li_diff drives its LI_RIGHT input.

Parameters:
NBITS, 18, width of audio inputs and matrixed outputs (signed two's complement)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
clken_48  in  1  single-cycle 48 kHz sample strobe; left_in/right_in valid in this cycle
clken_192  in  1  single-cycle 192 kHz strobe; every clken_48 pulse coincides with a clken_192 pulse
left_in  in  NBITS  signed left audio sample
right_in  in  NBITS  signed right audio sample
li_sum  out  NBITS  signed interpolated (L+R)/2, registered
li_diff  out  NBITS  signed interpolated (L-R)/2, registered
ready_192  out  1  one-cycle pulse when li_sum/li_diff update
sync_err  out  1  sticky flag: clken_192 arrived at phase 3 without clken_48

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clock. All state changes on posedge clock.
- Reset values: li_sum=0, li_diff=0, ready_192=0, sync_err=0. Internal prev/cur registers for both channels = 0. phase=3.
- Matrix:
  - m_sum = (left_in + right_in) >>> 1; m_diff = (left_in - right_in) >>> 1.
  - Compute at NBITS+1 bits; arithmetic shift rounds toward -inf.
  - The result always fits NBITS; no saturation logic.
- Sample capture (cycle T, clken_48=1): prev<=cur and cur<=matrixed inputs, per channel. Happens regardless of clken_192.
- Phase counter (2 bits), updated only on clken_192:
  - clken_48 also high: phase<=0.
  - Otherwise, if phase<3: phase<=phase+1.
  - Otherwise (phase==3): phase holds at 3 and sync_err<=1. No extrapolation.
- Interpolation (stage 2, cycle T+1 after any clken_192 at cycle T):
  - Per channel, using post-update prev/cur/phase: delta = cur - prev (NBITS+1 bits).
  - k*delta built by shift/add: k=0→0, 1→delta, 2→delta<<1, 3→delta+(delta<<1). Width NBITS+3.
  - out = prev + ((k*delta) >>> 2), arithmetic shift (floor). The result lies between prev and cur, so truncation to NBITS is lossless.
- Output timing:
  - li_sum/li_diff are registered at T+1; ready_192=1 for exactly cycle T+1, else 0.
  - Latency: clken_48 at T → first output (= old cur) at T+1.
  - The new sample appears as the phase-0 output one 48 kHz period later. Group delay is one input sample plus one clock.
- Outputs hold between updates. clken_48 without clken_192 still captures the sample; phase is unchanged.
- sync_err clears only on reset.
- Reset mid-operation: all state returns to reset values on the next edge. The first clken_192 after reset with no clken_48 sets sync_err (phase already 3).
- Both strobes high in the same cycle is the normal case: capture and phase<=0 occur together, and the T+1 output uses the new prev/cur.

Test Plan:
1. Reset, then four 48 kHz periods of L=R=1000 → li_sum settles at 1000, li_diff at 0. ready_192 pulses once per clken_192, each pulse one clock after the strobe.
2. Ramp: sum goes 0 then 400 (L=R=400 after a zero sample), diff held at 0 → the four li_sum outputs following the 400 capture are 0,100,200,300. After the next clken_48 (L=R=400) they are 400,400,400,400.
3. Negative floor: prev sum=0, cur sum=-3 (L=-3, R=-3) → li_sum sequence 0,-1,-2,-3.
4. Extremes: L=131071, R=-131072, held two periods → li_sum=-1, li_diff=131071, no overflow. Swap L and R → li_diff=-131072.
5. Missing strobe: suppress one clken_48 → at the fifth clken_192, li_sum/li_diff hold the cur value and sync_err rises to 1 and stays. It stays 1 after normal strobes resume; reset clears it to 0.
6. Reset asserted for one cycle mid-phase 2 with nonzero outputs → next cycle li_sum=li_diff=0, ready_192=0. The following clken_192 sets sync_err unless it coincides with clken_48.
